path_gen: RTL and testbench

PATH_GEN -- requirements
Module: path_gen

---
 rtl/mc_pkg.sv | 35 +++
 rtl/path_gen_if.sv | 29 ++
 rtl/lfsr16.sv | 36 +++
 rtl/path_gen.sv | 135 +++++++++++++
 tb/tb_path_gen.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/mc_pkg.sv
// Shared constants, state encoding and LFSR helpers for the Monte Carlo path
// generator and its consumer core.
package mc_pkg;

  localparam int unsigned DAY   = 8;
  localparam int unsigned N     = 128;
  localparam int unsigned DayW  = 3;
  localparam int unsigned PathW = 7;
  localparam int unsigned DataW = 12;
  localparam int unsigned FracW = 11;
  localparam int unsigned LfsrW = 16;

  localparam logic [LfsrW-1:0] SEED_ALT  = 16'hACE1;
  localparam logic [LfsrW-1:0] LFSR_MASK = 16'hB400;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StGen    = 2'd1,
    StStream = 2'd2,
    StDone   = 2'd3
  } state_e;

  // Right-shifting Galois step for x^16+x^14+x^13+x^11+1.
  function automatic logic [LfsrW-1:0] lfsr_next(input logic [LfsrW-1:0] cur);
    return (cur >> 1) ^ (cur[0] ? LFSR_MASK : '0);
  endfunction

  // Bit 0 of the state after one step; this is the up/down decision bit.
  function automatic logic lfsr_bit(input logic [LfsrW-1:0] cur);
    logic [LfsrW-1:0] nxt;
    nxt = lfsr_next(cur);
    return nxt[0];
  endfunction

endpackage

// File: rtl/path_gen_if.sv
// Configuration, status and path-sample stream between the path generator and
// its controller / consumer.
interface path_gen_if;
  import mc_pkg::*;

  logic                 start;
  logic [DataW-1:0]     s0;
  logic [DataW-1:0]     up_f;
  logic [DataW-1:0]     dn_f;
  logic [LfsrW-1:0]     seed;
  logic                 out_ready;
  logic                 out_valid;
  logic [DataW-1:0]     path;
  logic [DayW-1:0]      out_day;
  logic                 out_last;
  logic                 busy;
  logic                 done;

  modport master (
    output start, s0, up_f, dn_f, seed, out_ready,
    input  out_valid, path, out_day, out_last, busy, done
  );

  modport slave (
    input  start, s0, up_f, dn_f, seed, out_ready,
    output out_valid, path, out_day, out_last, busy, done
  );

endinterface

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR with synchronous load (zero seed replaced by SEED_ALT)
// and single-step advance.
module lfsr16
  import mc_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [LfsrW-1:0] seed,
  input  logic             step,
  output logic [LfsrW-1:0] q
);

  logic [LfsrW-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      // An all-zero state would lock the register up.
      q_d = (seed == '0) ? SEED_ALT : seed;
    end else if (step) begin
      q_d = lfsr_next(q_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= SEED_ALT;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/path_gen.sv
// Binomial Monte Carlo path generator: fills an N x DAY price table one sample
// per cycle, then streams it out latest day first under valid/ready.
module path_gen
  import mc_pkg::*;
(
  input logic       clk,
  input logic       rst_n,
  path_gen_if.slave bus
);

  localparam logic [DayW-1:0]  DayLast  = DayW'(DAY - 1);
  localparam logic [PathW-1:0] PathLast = PathW'(N - 1);

  state_e            state_q, state_d;
  logic [DayW-1:0]   day_q, day_d;
  logic [PathW-1:0]  p_q, p_d;
  logic [DataW-1:0]  up_q, dn_q;

  // Price table; contents are only meaningful after a start, so no reset.
  logic [DataW-1:0]  mem [DAY][N];

  logic              lfsr_load, lfsr_step;
  logic [LfsrW-1:0]  lfsr_q;
  logic [DayW-1:0]   day_prev;
  logic [DataW-1:0]  prev_val, factor, gen_val;
  logic [2*DataW-1:0] prod;
  logic [DataW:0]    scaled;

  assign lfsr_load = (state_q == StIdle) && bus.start;
  assign lfsr_step = (state_q == StGen);

  lfsr16 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (lfsr_load),
    .seed  (bus.seed),
    .step  (lfsr_step),
    .q     (lfsr_q)
  );

  assign day_prev = day_q - DayW'(1);
  assign prev_val = mem[day_prev][p_q];
  assign factor   = lfsr_bit(lfsr_q) ? up_q : dn_q;
  assign prod     = {{DataW{1'b0}}, prev_val} * {{DataW{1'b0}}, factor};
  assign scaled   = (DataW + 1)'(prod >> FracW);
  assign gen_val  = scaled[DataW] ? '1 : scaled[DataW-1:0];

  always_ff @(posedge clk) begin
    if (lfsr_load) begin
      for (int p = 0; p < N; p++) begin
        mem[0][p] <= bus.s0;
      end
    end else if (state_q == StGen) begin
      mem[day_q][p_q] <= gen_val;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      up_q <= '0;
      dn_q <= '0;
    end else if (lfsr_load) begin
      up_q <= bus.up_f;
      dn_q <= bus.dn_f;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      day_q   <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      day_q   <= day_d;
      p_q     <= p_d;
    end
  end

  always_comb begin
    state_d = state_q;
    day_d   = day_q;
    p_d     = p_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StGen;
          day_d   = DayW'(1);
          p_d     = '0;
        end
      end
      StGen: begin
        p_d = p_q + PathW'(1);
        if (p_q == PathLast) begin
          p_d = '0;
          // day_q already sits at DayLast, which is where streaming starts.
          if (day_q == DayLast) begin
            state_d = StStream;
          end else begin
            day_d = day_q + DayW'(1);
          end
        end
      end
      StStream: begin
        if (bus.out_ready) begin
          p_d = p_q + PathW'(1);
          if (p_q == PathLast) begin
            p_d = '0;
            if (day_q == '0) begin
              state_d = StDone;
            end else begin
              day_d = day_q - DayW'(1);
            end
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    bus.out_valid = (state_q == StStream);
    bus.path      = (state_q == StStream) ? mem[day_q][p_q] : '0;
    bus.out_day   = (state_q == StStream) ? day_q : '0;
    bus.out_last  = (state_q == StStream) && (day_q == '0) && (p_q == PathLast);
    bus.busy      = (state_q == StGen) || (state_q == StStream);
    bus.done      = (state_q == StDone);
  end

endmodule

// File: tb/tb_path_gen.sv
// Self-checking bench for path_gen: table of runs, reference price model feeding
// an expected-sample queue, plus stall, stray-start and mid-stream reset cases.
module tb_path_gen;
  import mc_pkg::*;

  typedef struct {
    logic [11:0] s0;
    logic [11:0] up;
    logic [11:0] dn;
    logic [15:0] seed;
    int          mode;        // 0: ready always, 1: random ready, 2: 5-cycle stall at 500
    bit          inj;         // pulse start during GEN and STREAM
    bit          done_start;  // pulse start in the DONE cycle
    int          abort_k;     // assert reset at this sample index (0: never)
  } vec_t;

  typedef struct packed {
    logic        last;
    logic [2:0]  day;
    logic [11:0] path;
  } smp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;

  smp_t        exp_q[$];
  logic [11:0] mm [8][128];
  vec_t        vecs [7];

  path_gen_if bus ();

  path_gen dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic push_expected(input logic [11:0] s0, input logic [11:0] up,
                               input logic [11:0] dn, input logic [15:0] seed);
    logic [15:0] l;
    logic [23:0] prod;
    logic [11:0] f;
    smp_t        s;
    l = (seed == 16'h0) ? 16'hACE1 : seed;
    for (int p = 0; p < 128; p++) mm[0][p] = s0;
    for (int d = 1; d < 8; d++) begin
      for (int p = 0; p < 128; p++) begin
        l    = l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
        f    = l[0] ? up : dn;
        prod = {12'h0, mm[d-1][p]} * {12'h0, f};
        mm[d][p] = ((prod >> 11) > 24'd4095) ? 12'd4095 : prod[22:11];
      end
    end
    for (int d = 7; d >= 0; d--) begin
      for (int p = 0; p < 128; p++) begin
        s.last = (d == 0) && (p == 127);
        s.day  = 3'(d);
        s.path = mm[d][p];
        exp_q.push_back(s);
      end
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_busy"},  32'(bus.busy),      32'd0);
    check({tag, "_done"},  32'(bus.done),      32'd0);
    check({tag, "_path"},  32'(bus.path),      32'd0);
    check({tag, "_day"},   32'(bus.out_day),   32'd0);
    check({tag, "_last"},  32'(bus.out_last),  32'd0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int   n, k, cyc, stall;
    bit   injected, hold_pending;
    smp_t held, cur, e;
    bus.s0 = v.s0;
    bus.up_f = v.up;
    bus.dn_f = v.dn;
    bus.seed = v.seed;
    bus.start = 1'b1;
    bus.out_ready = 1'b0;
    push_expected(v.s0, v.up, v.dn, v.seed);
    @(negedge clk);
    // Captured values must be used from here on, not the live inputs.
    bus.start = 1'b0;
    bus.s0 = 12'($urandom);
    bus.up_f = 12'($urandom);
    bus.dn_f = 12'($urandom);
    bus.seed = 16'($urandom);
    bus.out_ready = 1'b1;
    check($sformatf("v%0d_gen_busy", idx), 32'(bus.busy), 32'd1);
    check($sformatf("v%0d_gen_valid", idx), 32'(bus.out_valid), 32'd0);
    n = 1;
    while (!bus.out_valid && n < 2000) begin
      bus.start = v.inj && (n == 100);
      @(negedge clk);
      n++;
    end
    bus.start = 1'b0;
    check($sformatf("v%0d_gen_latency", idx), 32'(n), 32'd897);

    k = 0; cyc = 0; stall = 0; injected = 0; hold_pending = 0;
    while (k < 1024 && cyc < 6000) begin
      case (v.mode)
        0: bus.out_ready = 1'b1;
        1: bus.out_ready = ($urandom_range(0, 3) != 0);
        default: begin
          bus.out_ready = !(k == 500 && stall < 5);
          if (k == 500 && stall < 5) stall++;
        end
      endcase
      bus.start = v.inj && (k == 200) && !injected;
      if (bus.start) injected = 1;
      if (v.abort_k != 0 && k == v.abort_k) begin
        bus.start = 1'b0;
        rst_n = 1'b0;
        #1;
        check_idle_outputs($sformatf("v%0d_abort", idx));
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_outputs($sformatf("v%0d_post_abort", idx));
        return;
      end
      cur = {bus.out_last, bus.out_day, bus.path};
      check($sformatf("v%0d_stream_valid_%0d", idx, k), 32'(bus.out_valid), 32'd1);
      if (hold_pending) check($sformatf("v%0d_hold_%0d", idx, k), 32'(cur), 32'(held));
      hold_pending = 0;
      if (bus.out_ready) begin
        e = exp_q.pop_front();
        check($sformatf("v%0d_sample_%0d", idx, k), 32'(cur), 32'(e));
        k++;
      end else begin
        held = cur;
        hold_pending = 1;
      end
      @(negedge clk);
      cyc++;
    end
    bus.out_ready = 1'b0;
    bus.start = 1'b0;
    check($sformatf("v%0d_stream_count", idx), 32'(k), 32'd1024);
    check($sformatf("v%0d_done_pulse", idx), 32'(bus.done), 32'd1);
    check($sformatf("v%0d_done_valid", idx), 32'(bus.out_valid), 32'd0);
    check($sformatf("v%0d_done_busy", idx), 32'(bus.busy), 32'd0);
    if (v.done_start) bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check($sformatf("v%0d_done_clear", idx), 32'(bus.done), 32'd0);
    check($sformatf("v%0d_idle_busy", idx), 32'(bus.busy), 32'd0);
    @(negedge clk);
    check($sformatf("v%0d_idle_stays", idx), 32'(bus.busy), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{12'd1000, 12'd2048, 12'd2048, 16'hBEEF, 0, 1'b0, 1'b0, 0};
    vecs[1] = '{12'd4000, 12'd4095, 12'd4095, 16'h0001, 0, 1'b1, 1'b0, 0};
    vecs[2] = '{12'd2048, 12'd2048, 12'd1024, 16'h0000, 2, 1'b0, 1'b1, 0};
    vecs[3] = '{12'd3000, 12'd2500, 12'd1800, 16'h1234, 1, 1'b1, 1'b0, 0};
    vecs[4] = '{12'd3000, 12'd2500, 12'd1800, 16'h1234, 0, 1'b0, 1'b0, 300};
    vecs[5] = '{12'd3000, 12'd2500, 12'd1800, 16'h1234, 0, 1'b0, 1'b0, 0};
    vecs[6] = '{12'd4095, 12'd4095, 12'd100,  16'hFFFF, 1, 1'b0, 1'b0, 0};

    bus.start = 1'b0;
    bus.s0 = '0;
    bus.up_f = '0;
    bus.dn_f = '0;
    bus.seed = '0;
    bus.out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_idle_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("post_reset");

    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i], i);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
